trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap responder: consumes the encoded trap source produced by the jump unit, updates the M-mode trap CSRs, and redirects fetch to the handler; also executes `mret` and services CSR-instruction reads/writes. Sits beside the jump unit in execute; its `redirect`/`redirect_pc` feed the PC mux with priority over `taken`/`target`, and `stall` freezes the pipeline during the redirect cycle.

## Interface
Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec (low 2 bits forced 0)

Ports (clock `clk`, reset `rst`: one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- trap_src  in  5  encoded trap cause; 5'b11111 = no trap
- trap_pc  in  32  PC of faulting instruction
- trap_val  in  32  faulting address / instruction word
- mret  in  1  mret executing this cycle
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear
- csr_addr  in  12  CSR address
- csr_wdata  in  32  CSR operand (rs1 or zimm)
- csr_rdata  out  32  current value of addressed CSR (combinational)
- csr_illegal  out  1  csr_op!=0 and address unimplemented
- redirect  out  1  fetch must jump to redirect_pc
- redirect_pc  out  32  handler entry or return address
- stall  out  1  pipeline hold/flush

## Operation
- CSRs: mstatus 0x300 (MIE bit3, MPIE bit7 writable; MPP bits12:11 read 2'b11; rest 0), mtvec 0x305 (direct mode only, bits1:0 read 0), mscratch 0x340, mepc 0x341 (bits1:0 read 0), mcause 0x342, mtval 0x343, mcycle 0xB00, mcycleh 0xB80.
- FSM states IDLE, REDIRECT.
- IDLE, trap_src!=5'b11111: at clock edge mepc<=trap_pc&~3, mcause<={27'b0,trap_src}, mtval<=(trap_src==TRAP_M_ECALL or TRAP_BREAK)?0:trap_val, MPIE<=MIE, MIE<=0, redirect_pc_q<=mtvec, state<=REDIRECT.
- IDLE, mret (no trap): MIE<=MPIE, MPIE<=1, redirect_pc_q<=mepc, state<=REDIRECT.
- IDLE, csr_op!=0, no trap, no mret, address implemented: write=wdata, set=old|wdata, clear=old&~wdata; write masks per register applied. Unimplemented address: csr_illegal=1, no state change.
- Priority in one cycle: trap > mret > CSR op. Lower-priority operations are dropped.
- REDIRECT: redirect=1, stall=1, redirect_pc=redirect_pc_q; all inputs ignored; next state IDLE unconditionally.
- mcycle: 64-bit, increments every cycle incl. REDIRECT; wraps 2^64-1 -> 0. CSR write to a half replaces that half for that cycle (no increment that cycle); other half keeps value.
- csr_rdata reflects pre-edge value (read-old semantics); mcycle reads the current count.

## Timing
- Reset: state IDLE, redirect=0, stall=0, mstatus=0, mtvec=RESET_MTVEC&~3, mepc=mcause=mtval=mscratch=0, mcycle=0, redirect_pc_q=0.
- Trap/mret latency: detected in cycle N, redirect asserted exactly in cycle N+1 for one cycle, CSRs visible from N+1.
- Back-to-back trap presented during REDIRECT is ignored (pipeline is flushing); presented again in IDLE it is taken.
- rst asserted during REDIRECT: next cycle IDLE, redirect=0.
- csr_illegal, csr_rdata purely combinational, valid same cycle.

## Structure
- Shared header `trap.vh` (alongside `jump.vh`): TRAP_* cause codes, TRAP_NONE=5'b11111, CSR_* addresses, CSR_OP_* encodings, FSM state encodings.
- Sub-module `csr_file`: CSR storage, address decode, masks, mcycle counter; trap_ctrl holds FSM and redirect register.

## Test plan
- Reset then idle: mcycle reads 0 at first cycle, 5 after 5 cycles; redirect=0, stall=0.
- Write mtvec=32'h0000_0103, trap_src=TRAP_INS_ILLEGAL, trap_pc=32'h80, trap_val=32'hFFFF_FFFF -> next cycle redirect=1, redirect_pc=32'h100, mepc=32'h80, mcause=2, mtval=32'hFFFF_FFFF, MIE=0.
- Set MIE, trap TRAP_M_ECALL at pc 32'h200, then mret -> mtval=0, MPIE=1 after trap; mret redirects to 32'h200, MIE=1, MPIE=1.
- Trap, mret and csr write to mscratch same cycle -> trap taken, mscratch unchanged, mepc updated.
- Write mcycle=32'hFFFF_FFFF, mcycleh=32'hFFFF_FFFF -> one cycle later both halves read 0.
- csr_op=write to 0x7C0 -> csr_illegal=1, no CSR changes; trap during REDIRECT -> ignored.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | trap_ctrl_pkg : trap cause codes, CSR addresses, op/state encodings    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package trap_ctrl_pkg;

  localparam logic [4:0] TRAP_INS_MISALIGN = 5'd0;
  localparam logic [4:0] TRAP_INS_FAULT    = 5'd1;
  localparam logic [4:0] TRAP_INS_ILLEGAL  = 5'd2;
  localparam logic [4:0] TRAP_BREAK        = 5'd3;
  localparam logic [4:0] TRAP_LD_MISALIGN  = 5'd4;
  localparam logic [4:0] TRAP_LD_FAULT     = 5'd5;
  localparam logic [4:0] TRAP_ST_MISALIGN  = 5'd6;
  localparam logic [4:0] TRAP_ST_FAULT     = 5'd7;
  localparam logic [4:0] TRAP_M_ECALL      = 5'd11;
  localparam logic [4:0] TRAP_NONE         = 5'b11111;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_csr_file.sv
// +----------------------------------------------------------------------+
// | csr_file : M-mode trap CSR storage, address decode, mcycle counter     |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module csr_file
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_take,
  input  logic [4:0]  trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret_take,
  input  logic        csr_we,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;
  logic        w_impl;
  logic [31:0] w_wval;

  always_comb begin
    csr_rdata = 32'h0;
    w_impl    = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = {19'h0, 2'b11, 3'h0, r_mpie, 3'h0, r_mie, 3'h0};
      CSR_MTVEC:    csr_rdata = r_mtvec;
      CSR_MSCRATCH: csr_rdata = r_mscratch;
      CSR_MEPC:     csr_rdata = r_mepc;
      CSR_MCAUSE:   csr_rdata = r_mcause;
      CSR_MTVAL:    csr_rdata = r_mtval;
      CSR_MCYCLE:   csr_rdata = r_mcycle[31:0];
      CSR_MCYCLEH:  csr_rdata = r_mcycle[63:32];
      default:      w_impl    = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_op != CSR_OP_NONE) && !w_impl;

  // Read-modify-write operand is the pre-edge read value, so masked bits stay masked.
  always_comb begin
    case (csr_op)
      CSR_OP_SET:   w_wval = csr_rdata | csr_wdata;
      CSR_OP_CLEAR: w_wval = csr_rdata & ~csr_wdata;
      default:      w_wval = csr_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= RESET_MTVEC & ~32'h3;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
      r_mtval    <= 32'h0;
      r_mcycle   <= 64'h0;
    end else begin
      if (trap_take) begin
        r_mepc   <= trap_pc & ~32'h3;
        r_mcause <= {27'h0, trap_cause};
        r_mtval  <= (trap_cause == TRAP_M_ECALL || trap_cause == TRAP_BREAK) ? 32'h0 : trap_val;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (mret_take) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mie  <= w_wval[3];
            r_mpie <= w_wval[7];
          end
          CSR_MTVEC:    r_mtvec    <= w_wval & ~32'h3;
          CSR_MSCRATCH: r_mscratch <= w_wval;
          CSR_MEPC:     r_mepc     <= w_wval & ~32'h3;
          CSR_MCAUSE:   r_mcause   <= w_wval;
          CSR_MTVAL:    r_mtval    <= w_wval;
          default: ;
        endcase
      end

      // A write to either counter half replaces the increment for that cycle.
      if (csr_we && csr_addr == CSR_MCYCLE)
        r_mcycle[31:0] <= w_wval;
      else if (csr_we && csr_addr == CSR_MCYCLEH)
        r_mcycle[63:32] <= w_wval;
      else
        r_mcycle <= r_mcycle + 64'd1;
    end
  end

  assign mtvec = r_mtvec;
  assign mepc  = r_mepc;

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// +----------------------------------------------------------------------+
// | trap_ctrl : M-mode trap/mret responder with one-cycle fetch redirect   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  trap_src,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        stall
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_redirect_pc;
  logic        w_idle;
  logic        w_trap_take;
  logic        w_mret_take;
  logic        w_csr_we;
  logic [31:0] w_mtvec;
  logic [31:0] w_mepc;

  // Inputs are ignored while redirecting; the pipeline is being flushed.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_trap_take = w_idle && (trap_src != TRAP_NONE);
  assign w_mret_take = w_idle && mret && !w_trap_take;
  assign w_csr_we    = w_idle && (csr_op != CSR_OP_NONE) && !w_trap_take && !mret;

  csr_file #(
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr_file (
    .clk         (clk),
    .rst         (rst),
    .trap_take   (w_trap_take),
    .trap_cause  (trap_src),
    .trap_pc     (trap_pc),
    .trap_val    (trap_val),
    .mret_take   (w_mret_take),
    .csr_we      (w_csr_we),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .mtvec       (w_mtvec),
    .mepc        (w_mepc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_redirect_pc <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_trap_take)
        r_redirect_pc <= w_mtvec;
      else if (w_mret_take)
        r_redirect_pc <= w_mepc;
    end
  end

  always_comb begin
    w_next   = r_state;
    redirect = 1'b0;
    stall    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trap_take || w_mret_take)
          w_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect = 1'b1;
        stall    = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign redirect_pc = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_trap_ctrl : scoreboard bench for trap_ctrl against a CSR model      |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  trap_src;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;

  always #5 clk = ~clk;

  trap_ctrl #(.RESET_MTVEC(32'h0000_1007)) dut (
    .clk(clk), .rst(rst), .trap_src(trap_src), .trap_pc(trap_pc), .trap_val(trap_val),
    .mret(mret), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall)
  );

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        illegal;
    logic        redirect;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural CSR contents plus a pending-redirect flag.
  logic        m_mie, m_mpie, m_pend;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_ppc;
  logic [63:0] m_mc;

  function automatic bit impl(input logic [11:0] a);
    return a == 12'h300 || a == 12'h305 || a == 12'h340 || a == 12'h341 ||
           a == 12'h342 || a == 12'h343 || a == 12'hB00 || a == 12'hB80;
  endfunction

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_mc[31:0];
      12'hB80: return m_mc[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_pend = 0; m_ppc = 0;
    m_mtvec = 32'h0000_1004; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_mc = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // One cycle: drive inputs, predict this cycle's outputs, then advance the model.
  task automatic step(input logic r, input logic [4:0] src, input logic [31:0] pc,
                      input logic [31:0] val, input logic m, input logic [1:0] op,
                      input logic [11:0] a, input logic [31:0] wd);
    exp_t e;
    logic [31:0] old, nv;
    rst = r; trap_src = src; trap_pc = pc; trap_val = val; mret = m;
    csr_op = op; csr_addr = a; csr_wdata = wd;
    e.chk_rd   = impl(a);
    e.rdata    = model_rd(a);
    e.illegal  = (op != 2'b00) && !impl(a);
    e.redirect = m_pend;
    e.rpc      = m_ppc;
    q.push_back(e);
    if (r) model_reset();
    else if (m_pend) begin
      m_pend = 0; m_mc = m_mc + 1;
    end else if (src != 5'b11111) begin
      m_mepc = {pc[31:2], 2'b00};
      m_mcause = 32'(src);
      m_mtval = (src == 5'd11 || src == 5'd3) ? 32'h0 : val;
      m_mpie = m_mie; m_mie = 0;
      m_ppc = m_mtvec; m_pend = 1;
      m_mc = m_mc + 1;
    end else if (m) begin
      m_mie = m_mpie; m_mpie = 1;
      m_ppc = m_mepc; m_pend = 1;
      m_mc = m_mc + 1;
    end else if (op != 2'b00 && impl(a)) begin
      old = model_rd(a);
      nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
      m_mc = m_mc + 1;
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec = {nv[31:2], 2'b00};
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = {nv[31:2], 2'b00};
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: m_mc = {m_mc[63:32] - ((m_mc[31:0] == 32'h0) ? 32'd1 : 32'd0), nv};
        12'hB80: m_mc = {nv, m_mc[31:0] - 32'd1};
        default: ;
      endcase
    end else m_mc = m_mc + 1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("redirect", 32'(redirect), 32'(e.redirect));
      check("stall", 32'(stall), 32'(e.redirect));
      if (e.redirect) check("redirect_pc", redirect_pc, e.rpc);
      check("csr_illegal", 32'(csr_illegal), 32'(e.illegal));
      if (e.chk_rd) check($sformatf("csr_rdata[%h]", csr_addr), csr_rdata, e.rdata);
    end
  end

  localparam logic [4:0] NT = 5'b11111;

  initial begin
    logic [11:0] addrs [10];
    logic [4:0]  causes [9];
    logic [4:0]  s;
    logic [11:0] a;
    logic [1:0]  op;
    addrs  = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00, 12'hB80, 12'h7C0, 12'h301};
    causes = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd11};
    rst = 1; trap_src = NT; trap_pc = 0; trap_val = 0; mret = 0;
    csr_op = 0; csr_addr = 12'h300; csr_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Idle count-up from reset, then reset-state reads.
    repeat (6) step(0, NT, 0, 0, 0, 2'b00, 12'hB00, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h305, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h300, 0);
    // mtvec write, then illegal-instruction trap.
    step(0, NT, 0, 0, 0, 2'b01, 12'h305, 32'h0000_0103);
    step(0, 5'd2, 32'h80, 32'hFFFF_FFFF, 0, 2'b00, 12'h305, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h341, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h342, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h343, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h300, 0);
    // Set MIE, ecall, then mret.
    step(0, NT, 0, 0, 0, 2'b10, 12'h300, 32'h8);
    step(0, 5'd11, 32'h200, 32'h1234, 0, 2'b00, 12'h300, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h343, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h300, 0);
    step(0, NT, 0, 0, 1, 2'b00, 12'h341, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h300, 0);
    // Trap, mret and mscratch write together: trap wins.
    step(0, 5'd2, 32'h47, 32'h5, 1, 2'b01, 12'h340, 32'hDEAD_BEEF);
    step(0, NT, 0, 0, 0, 2'b00, 12'h340, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h341, 0);
    // Counter wrap through both halves.
    step(0, NT, 0, 0, 0, 2'b01, 12'hB00, 32'hFFFF_FFFF);
    step(0, NT, 0, 0, 0, 2'b01, 12'hB80, 32'hFFFF_FFFF);
    step(0, NT, 0, 0, 0, 2'b00, 12'hB00, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'hB80, 0);
    // Unimplemented CSR, back-to-back trap during REDIRECT, retaken in IDLE.
    step(0, NT, 0, 0, 0, 2'b01, 12'h7C0, 32'h1);
    step(0, 5'd5, 32'h300, 32'hAAAA, 0, 2'b00, 12'h342, 0);
    step(0, 5'd7, 32'h400, 32'hBBBB, 0, 2'b00, 12'h342, 0);
    step(0, 5'd7, 32'h400, 32'hBBBB, 0, 2'b00, 12'h342, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h342, 0);
    // Reset while redirecting.
    step(0, 5'd1, 32'h500, 32'h9, 0, 2'b00, 12'h341, 0);
    step(1, NT, 0, 0, 0, 2'b00, 12'h341, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'h341, 0);
    step(0, NT, 0, 0, 0, 2'b00, 12'hB00, 0);

    for (int i = 0; i < 1500; i++) begin
      s  = ($urandom_range(0, 7) == 0) ? causes[$urandom_range(0, 8)] : NT;
      op = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a  = addrs[$urandom_range(0, 9)];
      step(($urandom_range(0, 299) == 0), s, $urandom, $urandom,
           ($urandom_range(0, 9) == 0), op, a, $urandom);
    end

    trap_src = NT; mret = 0; csr_op = 0; rst = 0;
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
